ps2_key_receiver: RTL and testbench

Parametrised PS/2 keyboard receiver that replaces the fixed two-nibble keyboard decoder and external switch-debounce path. It takes raw, asynchronous PS2_CLK and PS2_DATA pins, synchronises and glitch-filters them, and checks frame format (start, odd parity, stop) with a bus-idle timeout. It folds the E0 (extended) and F0 (break) prefixes into single key events and buffers them in a FIFO with valid/ready output. Game and VGA control logic consume key press/release events from the FIFO instead of sampling a strobe.

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_key_receiver_fifo.sv | 46 ++++
 rtl/ps2_key_receiver.sv | 141 ++++++++++++++
 tb/tb_ps2_key_receiver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared prefix codes, frame-state enum and key-event record for the PS/2 receiver
package ps2_pkg;
  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;
endpackage

// File: rtl/ps2_key_receiver_fifo.sv
// ps2_event_fifo: first-word-fall-through key-event FIFO
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_data write side;
// i_pop request (ignored when empty); o_data head entry (zero when empty);
// o_full/o_empty status; o_count stored entries.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  ps2_evt_t                 i_data,
  input  logic                     i_pop,
  output ps2_evt_t                 o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  ps2_evt_t          r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_cnt;
  logic              w_pop;
  logic              w_push;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  assign o_count = r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard receiver with filtering, frame checks, prefix merge and event FIFO
// Ports: CLK/ARST_L system clock and async active-low reset; PS2_CLK/PS2_DATA raw pins;
// EVT_VALID/EVT_READY/EVT_CODE/EVT_EXT/EVT_BREAK event stream; EVT_COUNT stored events;
// FRAME_ERR one-cycle error pulse; OVERFLOW sticky dropped-event flag.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          CLK,
  input  logic                          ARST_L,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DATA,
  output logic                          EVT_VALID,
  input  logic                          EVT_READY,
  output logic [7:0]                    EVT_CODE,
  output logic                          EVT_EXT,
  output logic                          EVT_BREAK,
  output logic [$clog2(FIFO_DEPTH):0]   EVT_COUNT,
  output logic                          FRAME_ERR,
  output logic                          OVERFLOW
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0]   r_clk_s;
  logic [1:0]   r_dat_s;
  logic         r_flt;
  logic         r_flt_q;
  logic [FW-1:0] r_flt_cnt;
  frame_state_t r_state;
  logic [2:0]   r_bit;
  logic [7:0]   r_sh;
  logic         r_par;
  logic [TW-1:0] r_to;
  logic         r_good;
  logic         r_err;
  logic         r_ext_pend;
  logic         r_brk_pend;
  logic         r_ovf;
  logic         w_fall;
  logic         w_dat;
  logic         w_to;
  logic         w_ok;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  ps2_evt_t     w_head;
  assign w_fall = r_flt_q & ~r_flt;
  assign w_dat  = r_dat_s[1];
  assign w_to   = (r_state != IDLE) && (r_to == TW'(TIMEOUT_CYCLES - 1));
  assign w_ok   = w_dat & (^r_sh ^ r_par);
  // r_sh holds the completed byte for the cycle after r_good; prefixes are absorbed, not queued
  assign w_push = r_good && (r_sh != PS2_EXT_PREFIX) && (r_sh != PS2_BRK_PREFIX);
  assign w_pop  = EVT_READY & ~w_empty;
  // idle-high pins: synchroniser and filter reset to 1 so release never looks like an edge
  always_ff @(posedge CLK or negedge ARST_L)
    if (!ARST_L) begin
      r_clk_s   <= 2'b11;
      r_dat_s   <= 2'b11;
      r_flt     <= 1'b1;
      r_flt_q   <= 1'b1;
      r_flt_cnt <= '0;
    end else begin
      r_clk_s   <= {r_clk_s[0], PS2_CLK};
      r_dat_s   <= {r_dat_s[0], PS2_DATA};
      r_flt_q   <= r_flt;
      r_flt     <= (r_clk_s[1] != r_flt && r_flt_cnt == FW'(FILTER_LEN - 1)) ? r_clk_s[1] : r_flt;
      r_flt_cnt <= (r_clk_s[1] == r_flt || r_flt_cnt == FW'(FILTER_LEN - 1)) ? '0 : r_flt_cnt + 1'b1;
    end
  always_ff @(posedge CLK or negedge ARST_L)
    if (!ARST_L) r_to <= '0;
    else         r_to <= (w_fall || r_state == IDLE) ? '0 : r_to + 1'b1;
  always_ff @(posedge CLK or negedge ARST_L)
    if (!ARST_L) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_good  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_good <= 1'b0;
      r_err  <= 1'b0;
      if (w_to) begin
        r_state <= IDLE;
        r_err   <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          IDLE: if (!w_dat) begin
            r_state <= DATA;
            r_bit   <= '0;
          end
          DATA: begin
            r_sh    <= {w_dat, r_sh[7:1]};
            r_bit   <= r_bit + 3'd1;
            r_state <= (r_bit == 3'd7) ? PARITY : DATA;
          end
          PARITY: begin
            r_par   <= w_dat;
            r_state <= STOP;
          end
          default: begin
            r_good  <= w_ok;
            r_err   <= ~w_ok;
            r_state <= IDLE;
          end
        endcase
      end
    end
  // each prefix keeps the other pending flag so E0 F0 and F0 E0 both merge
  always_ff @(posedge CLK or negedge ARST_L)
    if (!ARST_L) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_ext_pend <= ~r_err & (r_good ? (r_sh == PS2_EXT_PREFIX) | ((r_sh == PS2_BRK_PREFIX) & r_ext_pend) : r_ext_pend);
      r_brk_pend <= ~r_err & (r_good ? (r_sh == PS2_BRK_PREFIX) | ((r_sh == PS2_EXT_PREFIX) & r_brk_pend) : r_brk_pend);
      r_ovf      <= r_ovf | (w_push & w_full & ~w_pop);
    end
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (ARST_L),
    .i_push  (w_push),
    .i_data  ('{ext: r_ext_pend, brk: r_brk_pend, code: r_sh}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (EVT_COUNT)
  );
  assign EVT_VALID = ~w_empty;
  assign EVT_CODE  = w_head.code;
  assign EVT_EXT   = w_head.ext;
  assign EVT_BREAK = w_head.brk;
  assign FRAME_ERR = r_err;
  assign OVERFLOW  = r_ovf;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: directed self-checking bench with an event scoreboard
module tb_ps2_key_receiver;
  localparam int H = 20;
  logic       CLK = 1'b0;
  logic       ARST_L = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic       EVT_READY = 1'b1;
  logic       EVT_VALID;
  logic [7:0] EVT_CODE;
  logic       EVT_EXT;
  logic       EVT_BREAK;
  logic [2:0] EVT_COUNT;
  logic       FRAME_ERR;
  logic       OVERFLOW;
  int         checks = 0;
  int         errors = 0;
  int         fe_pulses = 0;
  logic       fe_prev = 1'b0;
  logic [9:0] sb[$];
  logic [9:0] exp_ev;

  ps2_key_receiver #(.FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
    .CLK(CLK), .ARST_L(ARST_L), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_CODE(EVT_CODE),
    .EVT_EXT(EVT_EXT), .EVT_BREAK(EVT_BREAK), .EVT_COUNT(EVT_COUNT),
    .FRAME_ERR(FRAME_ERR), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (ARST_L && EVT_VALID && EVT_READY) begin
      chk("event_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_ev = sb.pop_front();
        chk("event", {22'd0, EVT_EXT, EVT_BREAK, EVT_CODE}, {22'd0, exp_ev});
      end
    end
    if (FRAME_ERR) begin
      chk("frame_err_width", 32'(fe_prev), 32'd0);
      if (!fe_prev) fe_pulses++;
    end
    fe_prev = FRAME_ERR;
  end

  task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                      input int nbits = 11, input bit lat = 0);
    logic [10:0] fr;
    fr = {~bad_stop, ~^b ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = fr[i];
      repeat (H) @(negedge CLK);
      PS2_CLK = 1'b0;
      if (lat && i == 10) begin
        repeat (7) @(negedge CLK);
        chk("valid_latency_early", 32'(EVT_VALID), 32'd0);
        @(negedge CLK);
        chk("valid_latency_on", 32'(EVT_VALID), 32'd1);
        repeat (H - 8) @(negedge CLK);
      end else repeat (H) @(negedge CLK);
      PS2_CLK = 1'b1;
    end
    PS2_DATA = 1'b1;
    repeat (2 * H) @(negedge CLK);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(EVT_VALID), 32'd0);
    chk({tag, "_code"}, 32'(EVT_CODE), 32'd0);
    chk({tag, "_ext"}, 32'(EVT_EXT), 32'd0);
    chk({tag, "_break"}, 32'(EVT_BREAK), 32'd0);
    chk({tag, "_count"}, 32'(EVT_COUNT), 32'd0);
    chk({tag, "_frame_err"}, 32'(FRAME_ERR), 32'd0);
    chk({tag, "_overflow"}, 32'(OVERFLOW), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    ARST_L = 1'b1;
    repeat (5) @(negedge CLK);

    sb.push_back({2'b00, 8'h1C});
    send(8'h1C, 0, 0, 11, 1);
    chk("plain_drained", 32'(sb.size()), 32'd0);

    sb.push_back({2'b01, 8'h1C});
    send(8'hF0);
    send(8'h1C);
    sb.push_back({2'b11, 8'h74});
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    chk("prefix_drained", 32'(sb.size()), 32'd0);

    send(8'h1C, 1);
    chk("parity_err", 32'(fe_pulses), 32'd1);
    chk("parity_no_event", 32'(EVT_COUNT), 32'd0);
    sb.push_back({2'b00, 8'h1C});
    send(8'h1C);
    chk("after_parity_drained", 32'(sb.size()), 32'd0);

    sb.push_back({2'b00, 8'h74});
    send(8'hE0);
    send(8'h55, 0, 1);
    chk("stop_err", 32'(fe_pulses), 32'd2);
    send(8'h74);
    chk("stop_drained", 32'(sb.size()), 32'd0);

    send(8'h1C, 0, 0, 5);
    repeat (300) @(negedge CLK);
    chk("timeout_err", 32'(fe_pulses), 32'd3);
    sb.push_back({2'b00, 8'h1C});
    send(8'h1C);
    chk("after_timeout_drained", 32'(sb.size()), 32'd0);

    EVT_READY = 1'b0;
    sb.push_back({2'b00, 8'h15});
    sb.push_back({2'b00, 8'h1D});
    sb.push_back({2'b00, 8'h24});
    sb.push_back({2'b00, 8'h2D});
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    chk("full_no_overflow", 32'(OVERFLOW), 32'd0);
    send(8'h2C);
    chk("full_count", 32'(EVT_COUNT), 32'd4);
    chk("overflow_set", 32'(OVERFLOW), 32'd1);
    chk("full_head", 32'(EVT_CODE), 32'h15);
    EVT_READY = 1'b1;
    repeat (20) @(negedge CLK);
    chk("overflow_drained", 32'(sb.size()), 32'd0);
    chk("drain_count", 32'(EVT_COUNT), 32'd0);
    chk("overflow_sticky", 32'(OVERFLOW), 32'd1);

    EVT_READY = 1'b0;
    send(8'h1C);
    chk("held_count", 32'(EVT_COUNT), 32'd1);
    send(8'h24, 0, 0, 4);
    ARST_L = 1'b0;
    sb.delete();
    @(negedge CLK);
    chk_reset_outputs("midframe_reset");
    ARST_L = 1'b1;
    repeat (5) @(negedge CLK);
    chk("post_reset_valid", 32'(EVT_VALID), 32'd0);
    EVT_READY = 1'b1;
    sb.push_back({2'b00, 8'h1C});
    send(8'h1C);
    chk("post_reset_drained", 32'(sb.size()), 32'd0);
    chk("post_reset_no_err", 32'(fe_pulses), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
